// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at a time, holds it for decode,
// and computes the next PC (sequential, branch or jump) when it is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [31:0] PC,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Beq,
  input  logic        Zero,
  output logic [1:0]  state_dbg
);

  // Handshakes: imem_req stays high with a stable imem_addr until a cycle with
  // imem_ack; instr_valid stays high with stable Instr/PC until a cycle with id_ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        taken;
  logic [31:0] pc_next;

  // All adds are plain 32-bit, so wrap-around at 2^32 falls out naturally.
  assign pc4     = PC + 32'd4;
  assign br_off  = {{14{Instr[15]}}, Instr[15:0], 2'b00};
  assign taken   = Branch & (Beq ? Zero : ~Zero);
  assign pc_next = Jump  ? {pc4[31:28], Instr[25:0], 2'b00} :
                   taken ? (pc4 + br_off) : pc4;

  assign imem_addr = PC;
  assign Op        = Instr[31:26];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      PC          <= RESET_PC_W;
      Instr       <= 32'h0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            Instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // No prefetch: the next request only goes out after this consume.
          if (id_ready) begin
            PC          <= pc_next;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= S_FETCH;
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch latency, stalls, next-PC selection,
// reset behaviour, and PC wrap / jump region on extra instances.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        instr_valid;
  logic        id_ready;
  logic        jump, branch, beq, zero;
  logic [1:0]  state_dbg;

  logic        aux_ack, aux_ready;
  logic [31:0] aux_rdata;
  logic        w_req, w_valid, j_req, j_valid;
  logic [31:0] w_addr, w_instr, w_pc, j_addr, j_instr, j_pc;
  logic [5:0]  w_op, j_op;
  logic [1:0]  w_state, j_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .Instr(instr), .Op(op),
    .PC(pc), .instr_valid(instr_valid), .id_ready(id_ready), .Jump(jump),
    .Branch(branch), .Beq(beq), .Zero(zero), .state_dbg(state_dbg)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(aux_ack), .imem_rdata(aux_rdata), .Instr(w_instr), .Op(w_op),
    .PC(w_pc), .instr_valid(w_valid), .id_ready(aux_ready), .Jump(1'b0),
    .Branch(1'b0), .Beq(1'b0), .Zero(1'b0), .state_dbg(w_state)
  );

  fetch_unit #(.RESET_PC(32'h4000_0008)) u_jmp (
    .clk(clk), .rst_n(rst_n), .imem_req(j_req), .imem_addr(j_addr),
    .imem_ack(aux_ack), .imem_rdata(aux_rdata), .Instr(j_instr), .Op(j_op),
    .PC(j_pc), .instr_valid(j_valid), .id_ready(aux_ready), .Jump(1'b1),
    .Branch(1'b0), .Beq(1'b0), .Zero(1'b0), .state_dbg(j_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits for a request, checks its address against the queue, acks after `delay` extra cycles.
  task automatic do_fetch(input int delay, input logic [31:0] data);
    int n;
    logic [31:0] exp_pc;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", {31'b0, imem_req}, 32'd1);
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", imem_addr, exp_pc);
    check("fetch_pc", pc, exp_pc);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("req_held", {31'b0, imem_req}, 32'd1);
      check("addr_held", imem_addr, exp_pc);
      check("no_early_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("op", {26'b0, op}, {26'b0, data[31:26]});
    check("req_drop", {31'b0, imem_req}, 32'd0);
    check("hold_pc", pc, exp_pc);
  endtask

  task automatic consume(input logic j, input logic b, input logic q, input logic z,
                         input logic [31:0] exp_next);
    jump = j; branch = b; beq = q; zero = z;
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; beq = 1'b0; zero = 1'b0;
    check("consume_valid", {31'b0, instr_valid}, 32'd0);
    check("consume_req", {31'b0, imem_req}, 32'd1);
    exp_q.push_back(exp_next);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, "_pc"},    pc, 32'd0);
    check({tag, "_addr"},  imem_addr, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_op"},    {26'b0, op}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    jump = 1'b0; branch = 1'b0; beq = 1'b0; zero = 1'b0;
    aux_ack = 1'b0; aux_ready = 1'b0; aux_rdata = 32'h0;

    // reset state, with an ack that must be ignored
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    check_reset_outputs("reset");

    // one IDLE cycle, then request; ack on the third request cycle
    rst_n = 1'b1;
    check("idle_no_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("idle_1cyc", {31'b0, imem_req}, 32'd1);
    exp_q.push_back(32'h0);
    do_fetch(2, 32'h2008_0005);

    // sequential consume, then a 5-cycle stall with stray acks and controls
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    do_fetch(0, 32'h0000_0020);
    for (int i = 0; i < 5; i++) begin
      jump = 1'($urandom); branch = 1'($urandom); zero = 1'($urandom);
      imem_ack = 1'b1; imem_rdata = $urandom;
      @(negedge clk);
      check("stall_instr", instr, 32'h0000_0020);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_pc", pc, 32'h4);
    end
    imem_ack = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;

    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h8);
    do_fetch(1, 32'h8C02_0004);
    consume(1'b0, 1'b0, 1'b1, 1'b1, 32'hC);    // Beq/Zero ignored without Branch
    do_fetch(0, 32'h1400_0010);
    consume(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);   // bne not taken
    do_fetch(0, 32'h1000_FFFC);
    consume(1'b0, 1'b1, 1'b1, 1'b1, 32'h04);   // beq taken backwards
    do_fetch(0, 32'h1000_0002);
    consume(1'b0, 1'b1, 1'b1, 1'b1, 32'h10);
    do_fetch(0, 32'h1000_FFFC);
    consume(1'b0, 1'b1, 1'b1, 1'b0, 32'h14);   // beq not taken
    do_fetch(0, 32'h1000_FFFE);
    consume(1'b0, 1'b1, 1'b1, 1'b1, 32'h10);
    do_fetch(0, 32'h1400_0002);
    consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h1C);   // bne taken
    do_fetch(0, 32'h0800_0003);
    consume(1'b1, 1'b1, 1'b1, 1'b1, 32'hC);    // jump beats branch
    do_fetch(1, 32'h0000_0020);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h10);

    // reset mid-FETCH, then a stray ack during IDLE
    @(negedge clk);
    check("midfetch_req", {31'b0, imem_req}, 32'd1);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    check("late_ack_instr", instr, 32'd0);
    check("restart_req", {31'b0, imem_req}, 32'd1);
    exp_q.push_back(32'h0);
    do_fetch(0, 32'h2008_0005);
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    do_fetch(0, 32'h0000_0020);

    // reset in HOLD discards the instruction and returns to RESET_PC
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // wrap and jump-region instances
    check("wrap_req", {31'b0, w_req}, 32'd1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    check("jmp_addr0", j_addr, 32'h4000_0008);
    aux_ack = 1'b1; aux_rdata = 32'h0800_0010;
    @(negedge clk);
    aux_ack = 1'b0;
    check("wrap_valid", {31'b0, w_valid}, 32'd1);
    check("jmp_op", {26'b0, j_op}, 32'd2);
    aux_ready = 1'b1;
    @(negedge clk);
    aux_ready = 1'b0;
    check("wrap_next", w_addr, 32'h0);
    check("wrap_req2", {31'b0, w_req}, 32'd1);
    check("jmp_next", j_addr, 32'h4000_0040);
    check("jmp_pc", j_pc, 32'h4000_0040);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
